lbist_scan_controller: RTL



---
 rtl/lbist_scan_controller.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/lbist_scan_controller.sv
// rtl/lbist_scan_controller.sv - logic-BIST sequencer: LFSR stimulus, scan/capture control, MISR signature check
//
// Ports:
//   CK, RST            clock (rising edge), asynchronous active-high reset
//   START              begin a run (honoured only in IDLE or DONE)
//   GOLDEN[31:0]       expected final signature, sampled in COMPARE
//   SCAN_OUT           last flop of the core scan chain
//   PO[PO_WIDTH-1:0]   core primary outputs, compacted at capture
//   SCAN_IN            first flop of the core scan chain
//   SE                 scan enable (1 = shift, 0 = functional/capture)
//   CAPTURE            one-cycle core clock-enable for the capture cycle
//   PI[PI_WIDTH-1:0]   core primary inputs, stable through capture
//   BUSY, DONE, PASS   run status; PASS valid only while DONE = 1
//   SIGNATURE[31:0]    current MISR contents

module lbist_scan_controller #(
   parameter int          CHAIN_LEN  = 19,
   parameter int          PI_WIDTH   = 35,
   parameter int          PO_WIDTH   = 24,
   parameter int          N_PATTERNS = 256,
   parameter logic [31:0] SEED       = 32'hACE1_0001
) (
   input  logic                CK,
   input  logic                RST,
   input  logic                START,
   input  logic [31:0]         GOLDEN,
   input  logic                SCAN_OUT,
   input  logic [PO_WIDTH-1:0] PO,
   output logic                SCAN_IN,
   output logic                SE,
   output logic                CAPTURE,
   output logic [PI_WIDTH-1:0] PI,
   output logic                BUSY,
   output logic                DONE,
   output logic                PASS,
   output logic [31:0]         SIGNATURE
);

   localparam int SC_W = $clog2(CHAIN_LEN + 1);
   localparam int PC_W = $clog2(N_PATTERNS + 1);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(CHAIN_LEN - 1);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(N_PATTERNS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SHIFT, S_CAPTURE, S_UNLOAD, S_COMPARE, S_DONE
   } state_t;

   // x^32 + x^22 + x^2 + x + 1, shifting toward bit 0 (bit 0 is the output)
   function automatic logic [31:0] poly_step(input logic [31:0] v);
      return {v[31] ^ v[21] ^ v[1] ^ v[0], v[31:1]};
   endfunction

   state_t              state_q;
   logic [31:0]         lfsr_q, lfsr_d;
   logic [31:0]         misr_q, misr_d;
   logic [PI_WIDTH-1:0] pi_q, pi_d;
   logic [SC_W-1:0]     shift_cnt_q;
   logic [PC_W-1:0]     pat_cnt_q;
   logic                scan_in_q, se_q, capture_q, busy_q, done_q, pass_q;
   logic [31:0]         po_fold;

   // Primary outputs folded into 32-bit chunks; missing upper bits act as zero.
   always_comb begin
      po_fold = '0;
      for (int i = 0; i < PO_WIDTH; i++) begin
         po_fold[i % 32] = po_fold[i % 32] ^ PO[i];
      end
   end

   always_comb begin
      lfsr_d = poly_step(lfsr_q);
      pi_d   = (pi_q << 1) | PI_WIDTH'(lfsr_q[31]);
      misr_d = poly_step(misr_q) ^ ((state_q == S_CAPTURE) ? po_fold : {31'b0, SCAN_OUT});
   end

   // Outputs are registered alongside the state: each branch loads the value
   // the output must show in the state being entered.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         lfsr_q      <= SEED;
         misr_q      <= '0;
         pi_q        <= '0;
         shift_cnt_q <= '0;
         pat_cnt_q   <= '0;
         scan_in_q   <= 1'b0;
         se_q        <= 1'b0;
         capture_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (START) begin
                  state_q     <= S_SHIFT;
                  lfsr_q      <= SEED;
                  misr_q      <= '0;
                  shift_cnt_q <= '0;
                  pat_cnt_q   <= '0;
                  done_q      <= 1'b0;
                  pass_q      <= 1'b0;
                  busy_q      <= 1'b1;
                  se_q        <= 1'b1;
                  scan_in_q   <= SEED[0];
               end
            end
            S_SHIFT: begin
               lfsr_q <= lfsr_d;
               pi_q   <= pi_d;
               // Pattern 0 unloads the unknown power-up chain contents; skip them.
               if (pat_cnt_q != '0) begin
                  misr_q <= misr_d;
               end
               if (shift_cnt_q == SC_LAST) begin
                  state_q     <= S_CAPTURE;
                  shift_cnt_q <= '0;
                  se_q        <= 1'b0;
                  scan_in_q   <= 1'b0;
                  capture_q   <= 1'b1;
               end else begin
                  shift_cnt_q <= shift_cnt_q + SC_W'(1);
                  scan_in_q   <= lfsr_d[0];
               end
            end
            S_CAPTURE: begin
               misr_q    <= misr_d;
               pat_cnt_q <= pat_cnt_q + PC_W'(1);
               capture_q <= 1'b0;
               se_q      <= 1'b1;
               if (pat_cnt_q == PC_LAST) begin
                  state_q   <= S_UNLOAD;
                  scan_in_q <= 1'b0;
               end else begin
                  state_q   <= S_SHIFT;
                  scan_in_q <= lfsr_q[0];
               end
            end
            S_UNLOAD: begin
               misr_q <= misr_d;
               if (shift_cnt_q == SC_LAST) begin
                  state_q     <= S_COMPARE;
                  shift_cnt_q <= '0;
                  se_q        <= 1'b0;
               end else begin
                  shift_cnt_q <= shift_cnt_q + SC_W'(1);
               end
            end
            S_COMPARE: begin
               state_q <= S_DONE;
               pass_q  <= (misr_q == GOLDEN);
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign SCAN_IN   = scan_in_q;
   assign SE        = se_q;
   assign CAPTURE   = capture_q;
   assign PI        = pi_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign PASS      = pass_q;
   assign SIGNATURE = misr_q;

endmodule
